// File: rtl/product_accumulator.sv
// product_accumulator
// Accumulates a block of COUNT consecutive 16-bit unsigned products from the
// upstream multiplier into an ACCW-bit sum. The finished sum is presented with
// a sticky wrap-around flag on a valid/ready output handshake. Input and output
// phases never overlap: the block takes products in ACCUM and shows its result
// in DONE.

module product_accumulator #(
    parameter int COUNT = 4,   // products per block, 2..256
    parameter int ACCW  = 32   // accumulator / result width, 16..64
) (
    input  logic            clk,
    input  logic            reset,      // asynchronous, active-low
    input  logic            clear,      // synchronous abort of block and result
    input  logic [15:0]     prod,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [ACCW-1:0] out_sum,
    output logic            out_ovf,
    output logic            out_valid,
    input  logic            out_ready
);

    // COUNT=256 still fits: cnt only has to reach COUNT-1.
    localparam int              CNTW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t          state;
    logic [ACCW-1:0] acc;
    logic [CNTW-1:0] cnt;
    logic            ovf;

    logic [ACCW:0]   sum_ext;   // MSB is the carry out of bit ACCW-1
    logic            accept;

    // Next partial sum with carry, and the input handshake qualifier.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned and a latch is never inferred.
        sum_ext = {1'b0, acc} + (ACCW + 1)'(prod);
        accept  = in_valid && (state == ACCUM);
    end

    // Handshake outputs are decoded from the state register only.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);

    // Block controller: accumulate, hand off the result, wait for downstream.
    // NOTE: all state here is updated with non-blocking assignments, so every
    // right-hand side reads the value from before this clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else if (clear) begin
            // Abort wins over any accept or output handshake in the same cycle.
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_sum <= '0;
            out_ovf <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (cnt == LAST) begin
                            // Last product of the block: publish and restart.
                            out_sum <= sum_ext[ACCW-1:0];
                            out_ovf <= ovf | sum_ext[ACCW];
                            acc     <= '0;
                            cnt     <= '0;
                            ovf     <= 1'b0;
                            state   <= DONE;
                        end else begin
                            acc     <= sum_ext[ACCW-1:0];
                            cnt     <= cnt + 1'b1;
                            ovf     <= ovf | sum_ext[ACCW];
                        end
                    end
                end
                DONE: begin
                    // Result holds until downstream takes it; inputs are ignored.
                    if (out_ready) begin
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
// Directed bench for product_accumulator. The main instance (COUNT=4, ACCW=32)
// is driven through a step task that runs a small reference model. The model
// pushes each completed block's expected result into a scoreboard queue; the
// entry is popped and compared when the DUT raises out_valid. A second instance
// (COUNT=2, ACCW=16) covers wrap-around and the overflow flag.

module tb_product_accumulator;

    localparam int COUNT = 4;
    localparam int ACCW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic            reset;
    logic            clear;
    logic [15:0]     prod;
    logic            in_valid;
    logic            in_ready;
    logic [ACCW-1:0] out_sum;
    logic            out_ovf;
    logic            out_valid;
    logic            out_ready;

    // Narrow instance signals
    logic            clear_w;
    logic [15:0]     prod_w;
    logic            in_valid_w;
    logic            in_ready_w;
    logic [15:0]     out_sum_w;
    logic            out_ovf_w;
    logic            out_valid_w;
    logic            out_ready_w;

    product_accumulator #(.COUNT(COUNT), .ACCW(ACCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .prod      (prod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    product_accumulator #(.COUNT(2), .ACCW(16)) dut_w (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_w),
        .prod      (prod_w),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .out_sum   (out_sum_w),
        .out_ovf   (out_ovf_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w)
    );

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
    } result_t;

    result_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the main instance
    bit          m_done;
    int          m_cnt;
    logic [63:0] m_acc;
    logic        m_ovf;
    logic [63:0] mask = (64'd1 << ACCW) - 64'd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_done = 1'b0;
        m_cnt  = 0;
        m_acc  = '0;
        m_ovf  = 1'b0;
    endtask

    // One clock of stimulus on the main instance. Inputs are driven at the
    // falling edge and outputs are compared at the next falling edge.
    task automatic step(input logic v, input logic [15:0] p, input logic r, input logic c);
        bit          was_done;
        logic [63:0] t;
        result_t     res;
        in_valid  = v;
        prod      = p;
        out_ready = r;
        clear     = c;
        was_done  = m_done;
        if (c) begin
            model_clear();
        end else if (!m_done) begin
            if (v) begin
                t = m_acc + 64'(p);
                if (t > mask) begin
                    m_ovf = 1'b1;
                    t     = t & mask;
                end
                m_acc = t;
                m_cnt++;
                if (m_cnt == COUNT) begin
                    res.sum = m_acc;
                    res.ovf = m_ovf;
                    sb_q.push_back(res);
                    model_clear();
                    m_done = 1'b1;
                end
            end
        end else if (r) begin
            m_done = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'(!m_done));
        check("out_valid", 64'(out_valid), 64'(m_done));
        if (m_done && !was_done) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                res = sb_q.pop_front();
                check("sb_sum", 64'(out_sum), res.sum);
                check("sb_ovf", 64'(out_ovf), 64'(res.ovf));
            end
        end
        clear = 1'b0;
    endtask

    // Assert reset halfway through the low clock phase and confirm the
    // outputs drop before any further clock edge.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_sum"}, 64'(out_sum), 64'd0);
        check({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        clear       = 1'b0;
        prod        = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        clear_w     = 1'b0;
        prod_w      = '0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;
        model_clear();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        reset = 1'b1;

        // Back-to-back block, downstream always ready: one-cycle DONE
        step(1'b1, 16'd15, 1'b1, 1'b0);
        step(1'b1, 16'd20, 1'b1, 1'b0);
        step(1'b1, 16'd65025, 1'b1, 1'b0);
        step(1'b1, 16'd0, 1'b1, 1'b0);
        check("blk1_sum", 64'(out_sum), 64'd65060);
        check("blk1_ovf", 64'(out_ovf), 64'd0);
        check("blk1_in_ready", 64'(in_ready), 64'd0);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Same block with a 5-cycle downstream stall and ignored input pulses
        step(1'b1, 16'd15, 1'b0, 1'b0);
        step(1'b1, 16'd20, 1'b0, 1'b0);
        step(1'b1, 16'd65025, 1'b0, 1'b0);
        step(1'b1, 16'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step((i % 2) == 0, 16'd99, 1'b0, 1'b0);
            check("stall_sum", 64'(out_sum), 64'd65060);
        end
        step(1'b0, 16'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 16'(i), 1'b1, 1'b0);
        end
        check("post_stall_sum", 64'(out_sum), 64'd10);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Abort after two accepts; the accept coinciding with clear is dropped
        step(1'b1, 16'd100, 1'b1, 1'b0);
        step(1'b1, 16'd200, 1'b1, 1'b0);
        step(1'b1, 16'd50, 1'b1, 1'b1);
        check("clear_out_sum", 64'(out_sum), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'd1, 1'b1, 1'b0);
        end
        check("clear_blk_sum", 64'(out_sum), 64'd4);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-block, then a full block
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'd10, 1'b1, 1'b0);
        end
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'd10, 1'b1, 1'b0);
        end
        check("rst_mid_blk_sum", 64'(out_sum), 64'd40);

        // Asynchronous reset while the result is on display
        async_reset("rst_done");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'd10, 1'b1, 1'b0);
        end
        check("rst_done_blk_sum", 64'(out_sum), 64'd40);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Alternating in_valid: result after the 7th cycle's edge (seen in cycle 8)
        for (int i = 0; i < 7; i++) begin
            step((i % 2) == 0, 16'd7, 1'b1, 1'b0);
        end
        check("toggle_sum", 64'(out_sum), 64'd28);
        step(1'b0, 16'd0, 1'b1, 1'b0);

        // Narrow instance: wrap-around sets the sticky flag
        in_valid_w = 1'b1;
        prod_w     = 16'd65025;
        @(posedge clk);
        @(negedge clk);
        check("w_mid_out_valid", 64'(out_valid_w), 64'd0);
        prod_w     = 16'd1000;
        @(posedge clk);
        @(negedge clk);
        check("w_out_valid", 64'(out_valid_w), 64'd1);
        check("w_wrap_sum", 64'(out_sum_w), 64'd489);
        check("w_wrap_ovf", 64'(out_ovf_w), 64'd1);
        in_valid_w = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w_in_ready", 64'(in_ready_w), 64'd1);
        in_valid_w = 1'b1;
        prod_w     = 16'd1;
        @(posedge clk);
        @(negedge clk);
        prod_w     = 16'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid_w = 1'b0;
        check("w_blk2_valid", 64'(out_valid_w), 64'd1);
        check("w_blk2_sum", 64'(out_sum_w), 64'd3);
        check("w_blk2_ovf", 64'(out_ovf_w), 64'd0);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage placed directly downstream of the 8x8 unsigned combinational multiplier (`multiplexerNbitv1`). It consumes the multiplier's 16-bit products through a valid/ready handshake and sums a fixed block of `COUNT` consecutive products into a wider accumulator. It then presents the block sum, with a sticky overflow flag, on an output valid/ready handshake. This turns the single-shot multiplier into a dot-product / MAC building block.

## Interface
- `COUNT`, default 4: products summed per block; legal range 2..256.
- `ACCW`, default 32: accumulator and `out_sum` width; legal range 16..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; all state cleared while low.
- `clear`  in  1  synchronous abort; discards the partial block and any pending result.
- `prod`  in  16  unsigned product from the multiplier (`y`).
- `in_valid`  in  1  `prod` is valid this cycle.
- `in_ready`  out  1  block can accept `prod` this cycle.
- `out_sum`  out  ACCW  block sum, zero-extended products, modulo 2^ACCW.
- `out_ovf`  out  1  a carry out of bit ACCW-1 occurred during this block.
- `out_valid`  out  1  `out_sum`/`out_ovf` hold a completed block.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Two states: ACCUM (reset state) and DONE.
- ACCUM:
  - `in_ready`=1, `out_valid`=0.
  - An accept is `in_valid && in_ready` at a rising edge.
  - On each accept: acc <= acc + zext(prod); cnt <= cnt+1; ovf <= ovf | carry.
  - When an accept occurs with cnt==COUNT-1: the final sum and ovf are latched into `out_sum`/`out_ovf`, acc, cnt and ovf are zeroed, and the state moves to DONE.
- DONE:
  - `in_ready`=0, `out_valid`=1.
  - `out_sum`/`out_ovf` are stable.
  - `out_valid && out_ready` at an edge returns the state to ACCUM.
- `in_ready` is a function of state only, never of `out_ready`. No overlap of the input and output phases.
- `in_valid` while `in_ready`=0 is ignored. The upstream must hold `prod`.
- Arithmetic is unsigned with width ACCW. Wrap-around is modulo 2^ACCW, and ovf records that a wrap occurred.
- `clear`=1 at an edge:
  - Highest priority over accept and output handshake.
  - Sets state ACCUM; acc, cnt, ovf, `out_sum`, `out_ovf` to 0.
  - Any accept in the same cycle is dropped.
- Reset values (`reset`=0): state ACCUM; `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0; acc, cnt, ovf = 0.
- Reset asserted mid-block or in DONE: the result is lost immediately and asynchronously. There is no recovery.

## Timing
- Throughput in ACCUM: one product per cycle.
- Latency: `out_valid` rises on the same edge as the COUNT-th accept and is visible in the following cycle.
- Minimum block period is COUNT+1 cycles: COUNT accepts plus one DONE cycle when `out_ready`=1.
- `in_ready` rises on the edge that completes the output handshake, so the next accept can occur in the next cycle.
- `out_ready` held high before `out_valid` rises: DONE lasts exactly one cycle.
- Gaps in `in_valid` stall accumulation without affecting acc or cnt.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.

## Test plan
- Reset then 4 back-to-back products 15 (3*5), 20 (4*5), 65025 (255*255), 0 (COUNT=4, ACCW=32), `out_ready`=1. Required:
  - `out_valid` high for exactly 1 cycle, with `out_sum`=65060 and `out_ovf`=0.
  - `in_ready` low that cycle.
- Same block with `out_ready`=0 for 5 cycles after `out_valid` rises. Required:
  - `out_sum` stays at 65060 and `in_ready` stays 0.
  - `in_valid` pulses during the stall are not counted.
  - After `out_ready` rises, the next block starts from 0.
- ACCW=16, COUNT=2, products 65025, 1000. Required: `out_sum`=(66025 mod 65536)=489, `out_ovf`=1. The following block of 1, 2 gives `out_sum`=3, `out_ovf`=0.
- Two accepts (100, 200), then `clear` pulsed together with a third `in_valid`, then 4 accepts of 1. Required: `out_sum`=4, and no `out_valid` before the 4th post-clear accept.
- `reset` driven low asynchronously (mid-cycle) after 3 accepts and again while in DONE. Required:
  - Outputs go immediately to the reset values: `out_valid`=0, `out_sum`=0, `in_ready`=1.
  - After release, a full block of 4x10 gives 40.
- `in_valid` toggling 1,0,1,0,... with product 7. Required: `out_valid` after the 4th accept (8th cycle), with `out_sum`=28.
